checked_fifo: RTL and testbench

CHECKED_FIFO -- requirements
Module: checked_fifo

---
 rtl/checked_fifo.sv | 184 ++++++++++++++++++
 tb/tb_checked_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/checked_fifo.sv
// checked_fifo: single-clock synchronous FIFO with registered read data,
// occupancy flags and sticky error reporting.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr_en        write request, wr_data stored when accepted
//   wr_data      write data
//   rd_en        read request, head entry loaded into rd_data when accepted
//   rd_data      registered read data (1-cycle latency, holds when no read)
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        current occupancy
//   ovf_err      sticky flag, set by a rejected write
//   unf_err      sticky flag, set by a rejected read
//   err_cnt      saturating count of rejected requests
//   err_clr      clears ovf_err, unf_err and err_cnt (errors that cycle win)
module checked_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err,
    output logic                     unf_err,
    output logic [ERR_W-1:0]         err_cnt,
    input  logic                     err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0]    DepthC   = CW'(DEPTH);
    localparam logic [CW-1:0]    AfLevelC = CW'(AF_LEVEL);
    localparam logic [CW-1:0]    AeLevelC = CW'(AE_LEVEL);
    localparam logic [ERR_W:0]   ErrMax   = {1'b0, {ERR_W{1'b1}}};

    // Storage is deliberately not reset; stale entries are unreachable
    // because the pointers and count are cleared.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             rd_acc, wr_acc;
    logic             rd_rej, wr_rej;
    logic [1:0]       n_err;
    logic [ERR_W:0]   n_err_ext;
    logic [ERR_W:0]   err_sum;
    logic [ERR_W-1:0] err_base;

    // Request acceptance. A read needs stored data (no fall-through from a
    // same-cycle write); a write into a full FIFO is allowed only when a
    // read frees the head slot on the same edge.
    always_comb begin
        rd_acc = rd_en && (count_q != '0);
        wr_acc = wr_en && ((count_q != DepthC) || rd_acc);
        rd_rej = rd_en && !rd_acc;
        wr_rej = wr_en && !wr_acc;
    end

    // Pointer, count and read-data next state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        // DEPTH is a power of two, so the AW-bit increment wraps
        // DEPTH-1 back to 0.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Error flags and counter. A clear in the same cycle as an error leaves
    // the flag set and the counter holding only this cycle's error count.
    always_comb begin
        n_err     = {1'b0, wr_rej} + {1'b0, rd_rej};
        n_err_ext = '0;
        n_err_ext[1:0] = n_err;

        err_base = err_clr ? '0 : err_cnt_q;
        err_sum  = {1'b0, err_base} + n_err_ext;

        if (err_sum > ErrMax) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = err_sum[ERR_W-1:0];
        end

        ovf_d = wr_rej ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        unf_d = rd_rej ? 1'b1 : (err_clr ? 1'b0 : unf_q);
    end

    // Control state; reset overrides every request, so nothing is accepted
    // or counted as an error while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Flags come straight from the registered count.
    always_comb begin
        full         = (count_q == DepthC);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AfLevelC);
        almost_empty = (count_q <= AeLevelC);
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
    assign err_cnt = err_cnt_q;

    // Simulation-only sanity checks; synthesis ignores immediate assertions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DepthC)
            else $error("%0t: count=%0d exceeds DEPTH=%0d", $time, count_q, DEPTH);
            assert (!(full && empty))
            else $error("%0t: full and empty both set, count=%0d", $time, count_q);
            assert (ovf_q || !ovf_d || wr_rej)
            else $error("%0t: ovf_err rising without rejected write (wr_en=%0b count=%0d)",
                        $time, wr_en, count_q);
            assert (unf_q || !unf_d || rd_rej)
            else $error("%0t: unf_err rising without rejected read (rd_en=%0b count=%0d)",
                        $time, rd_en, count_q);
        end
    end

endmodule

// File: tb/tb_checked_fifo.sv
module tb_checked_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       ovf_err, unf_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue plus plain error bookkeeping.
    logic [7:0] mq[$];
    int         m_rd = 0;
    int         m_ovf = 0;
    int         m_unf = 0;
    int         m_err = 0;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         c;
        int         rdv;
        int         o;
        int         u;
        int         e;
    } vec_t;

    vec_t tbl[$];

    checked_fifo #(
        .WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2), .AE_LEVEL(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .ovf_err(ovf_err),
        .unf_err(unf_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic rd, logic c,
                                int ec, int erd, int eo, int eu, int ee);
        vec_t v;
        v.rst = r; v.wr = w; v.wd = d; v.rd = rd; v.clr = c;
        v.c = ec; v.rdv = erd; v.o = eo; v.u = eu; v.e = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Full/empty/almost flags follow from the expected occupancy.
    task automatic check_state(input string tag, input int c, input int rdv,
                               input int o, input int u, input int e);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".rd_data"}, int'(rd_data), rdv);
        chk({tag, ".full"}, int'(full), int'(c == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(c == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(c >= DEPTH - 2));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(c <= 2));
        chk({tag, ".ovf_err"}, int'(ovf_err), o);
        chk({tag, ".unf_err"}, int'(unf_err), u);
        chk({tag, ".err_cnt"}, int'(err_cnt), e);
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [7:0] d,
                              input logic rd, input logic c);
        bit rd_ok, wr_ok;
        int nerr;
        if (r) begin
            mq.delete();
            m_rd = 0; m_ovf = 0; m_unf = 0; m_err = 0;
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
            nerr = int'(w && !wr_ok) + int'(rd && !rd_ok);
            if (rd_ok) m_rd = int'(mq.pop_front());
            if (wr_ok) mq.push_back(d);
            if (c) begin
                m_ovf = 0; m_unf = 0; m_err = 0;
            end
            if (w && !wr_ok) m_ovf = 1;
            if (rd && !rd_ok) m_unf = 1;
            m_err = m_err + nerr;
            if (m_err > 255) m_err = 255;
        end
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic rd, input logic c);
        @(negedge clk);
        rst = r; wr_en = w; wr_data = d; rd_en = rd; err_clr = c;
        @(posedge clk);
        model_edge(r, w, d, rd, c);
        #1;
    endtask

    initial begin
        // ---------------- table-driven directed sequence ----------------
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 1, 8'(i), 0, 0, i, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAA, 0, 0, 8, 0, 1, 0, 1));      // overflow
        tbl.push_back(mk(0, 1, 8'hBB, 1, 0, 8, 8'h01, 1, 0, 1));  // wr+rd when full
        for (int i = 2; i <= 8; i++)
            tbl.push_back(mk(0, 0, 8'h00, 1, 0, 9 - i, i, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'hBB, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'h55, 1, 0, 1, 8'hBB, 1, 1, 2));  // no fall-through
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hBB, 0, 0, 0));  // clear
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h55, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h55, 0, 1, 1));  // clear vs error
        tbl.push_back(mk(1, 1, 8'h77, 1, 1, 0, 0, 0, 0, 0));      // reset wins

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            check_state($sformatf("tbl%0d", i), tbl[i].c, tbl[i].rdv,
                        tbl[i].o, tbl[i].u, tbl[i].e);
        end

        // ---------------- wrap-around: 20 write/read pairs ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'(8'h10 + i), 0, 0);
            chk("wrap.count_w", int'(count), 1);
            step(0, 0, 0, 1, 0);
            chk("wrap.rd_data", int'(rd_data), 8'h10 + i);
            chk("wrap.count_r", int'(count), 0);
        end

        // ---------------- thresholds ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 8'(8'h30 + i), 0, 0);
            check_state($sformatf("thr_w%0d", i), i, 0, 0, 0, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, 0);
            check_state($sformatf("thr_r%0d", i), 6 - i, 8'h30 + i, 0, 0, 0);
        end

        // ---------------- error counter saturation ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(i), 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 8'hEE, 0, 0);
        check_state("sat", 8, 0, 1, 0, 255);
        step(0, 1, 8'hEE, 0, 1);
        check_state("sat_clr", 8, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0);
            chk("sat_drain", int'(rd_data), i);
        end

        // ---------------- reset mid-operation ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        step(0, 1, 8'hAA, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check_state("mid_pre", 5, 8'h42, 1, 0, 1);
        step(1, 1, 8'h99, 0, 0);
        check_state("mid_rst", 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_state("mid_post", 0, 0, 0, 1, 1);

        // ---------------- randomized against the model ----------------
        step(1, 0, 0, 0, 0);
        for (int p = 0; p < 8; p++) begin
            int pw;
            pw = (p % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 200; i++) begin
                logic r, w, rd, c;
                logic [7:0] d;
                r  = ($urandom_range(0, 199) == 0);
                w  = ($urandom_range(0, 99) < pw);
                rd = ($urandom_range(0, 99) < (100 - pw));
                c  = ($urandom_range(0, 29) == 0);
                d  = 8'($urandom);
                step(r, w, d, rd, c);
                check_state("rand", mq.size(), m_rd, m_ovf, m_unf, m_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
